cdb_arbiter: RTL

Shares one result-writeback bus between the two producers that feed the reorder buffer: the ALU reservation station and the load/store buffer. Each producer gets a small FIFO. A round-robin arbiter drains the two FIFOs onto a single registered bus (ready, rob_id, value), one result per cycle. The block sits between RS/LSB and the ROB writeback port, and is flushed by the ROB misprediction clear.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_if.sv | 45 ++++
 rtl/cdb_arbiter_src_fifo.sv | 64 ++++++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, source encoding and grant helper for the result-writeback bus arbiter.
// Both the RTL and the testbench import this package.
package cdb_arbiter_pkg;

   localparam int ROB_INDEX_BIT    = 3;
   localparam int CDB_FIFO_DEPTH   = 4;
   localparam int CDB_FIFO_PTR_BIT = 2;
   localparam int CDB_DATA_W       = 32;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   // With both sources competing, the one that did not win last time gets the bus.
   function automatic cdb_src_e cdb_pick(input logic cand_alu, input logic cand_lsb,
                                         input cdb_src_e last);
      cdb_src_e pick;
      pick = SRC_ALU;
      if (cand_alu && cand_lsb) begin
         pick = (last == SRC_ALU) ? SRC_LSB : SRC_ALU;
      end else if (cand_lsb) begin
         pick = SRC_LSB;
      end
      return pick;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side pushes, full flags and the registered writeback bus, bundled for the arbiter.
// Handshake: a producer may assert X_ready_in only while X_full_out is low; cdb_ready_out marks one result per cycle.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_INDEX_BIT = 3,
   parameter int FIFO_PTR_BIT  = 2
);

   logic                     alu_ready_in;
   logic [ROB_INDEX_BIT-1:0] alu_rob_id_in;
   logic [31:0]              alu_result_in;
   logic                     alu_full_out;

   logic                     lsb_ready_in;
   logic [ROB_INDEX_BIT-1:0] lsb_rob_id_in;
   logic [31:0]              lsb_result_in;
   logic                     lsb_full_out;

   logic                     cdb_ready_out;
   logic [ROB_INDEX_BIT-1:0] cdb_rob_id_out;
   logic [31:0]              cdb_val_out;

   // Observation points: FIFO occupancy and the round-robin state.
   logic [FIFO_PTR_BIT:0]    dbg_alu_count;
   logic [FIFO_PTR_BIT:0]    dbg_lsb_count;
   cdb_src_e                 dbg_last_grant;

   modport slave (
      input  alu_ready_in, alu_rob_id_in, alu_result_in,
      input  lsb_ready_in, lsb_rob_id_in, lsb_result_in,
      output alu_full_out, lsb_full_out,
      output cdb_ready_out, cdb_rob_id_out, cdb_val_out,
      output dbg_alu_count, dbg_lsb_count, dbg_last_grant
   );

   modport master (
      output alu_ready_in, alu_rob_id_in, alu_result_in,
      output lsb_ready_in, lsb_rob_id_in, lsb_result_in,
      input  alu_full_out, lsb_full_out,
      input  cdb_ready_out, cdb_rob_id_out, cdb_val_out,
      input  dbg_alu_count, dbg_lsb_count, dbg_last_grant
   );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Single-clock source FIFO with flush and hold; full/empty come straight from the count register.
// Flush beats hold, hold beats push/pop; a push while full is silently dropped.
module cdb_src_fifo #(
   parameter int DEPTH   = 4,
   parameter int PTR_BIT = 2,
   parameter int W       = 35
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             i_flush,
   input  logic             i_hold,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [W-1:0]     i_data,
   output logic [W-1:0]     o_head,
   output logic [PTR_BIT:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int CW = PTR_BIT + 1;

   logic [W-1:0]       r_mem [DEPTH];
   logic [PTR_BIT-1:0] r_rptr;
   logic [PTR_BIT-1:0] r_wptr;
   logic [CW-1:0]      r_count;

   logic w_active;
   logic w_push_ok;
   logic w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rptr];

   assign w_active  = !rst_in && !i_flush && !i_hold;
   assign w_push_ok = w_active && i_push && !o_full;
   assign w_pop_ok  = w_active && i_pop && !o_empty;

   // Pointers are PTR_BIT wide, so DEPTH being a power of two makes the wrap free.
   always_ff @(posedge clk_in) begin
      if (rst_in || i_flush) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= i_data;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining the ALU and LSB result FIFOs onto one registered writeback bus.
// An empty FIFO with a push pending competes with the incoming data directly (bypass).
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int ROB_INDEX_BIT = cdb_arbiter_pkg::ROB_INDEX_BIT,
   parameter int FIFO_DEPTH    = CDB_FIFO_DEPTH,
   parameter int FIFO_PTR_BIT  = CDB_FIFO_PTR_BIT
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          clear_in,
   cdb_arbiter_if.slave  bus
);

   localparam int W  = ROB_INDEX_BIT + 32;
   localparam int CW = FIFO_PTR_BIT + 1;

   logic [W-1:0]  w_alu_in, w_lsb_in;
   logic [W-1:0]  w_alu_head, w_lsb_head;
   logic [CW-1:0] w_alu_count, w_lsb_count;
   logic          w_alu_full, w_lsb_full;
   logic          w_alu_empty, w_lsb_empty;
   logic          w_alu_push, w_lsb_push;
   logic          w_alu_pop, w_lsb_pop;
   logic          w_alu_cand, w_lsb_cand;
   logic          w_grant_valid;
   cdb_src_e      w_grant_src;
   logic [W-1:0]  w_grant_data;

   logic                     r_cdb_ready;
   logic [ROB_INDEX_BIT-1:0] r_cdb_rob_id;
   logic [31:0]              r_cdb_val;
   cdb_src_e                 r_last_grant;

   assign w_alu_in = {bus.alu_rob_id_in, bus.alu_result_in};
   assign w_lsb_in = {bus.lsb_rob_id_in, bus.lsb_result_in};

   cdb_src_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .PTR_BIT (FIFO_PTR_BIT),
      .W       (W)
   ) u_alu_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_flush (clear_in),
      .i_hold  (!rdy_in),
      .i_push  (w_alu_push),
      .i_pop   (w_alu_pop),
      .i_data  (w_alu_in),
      .o_head  (w_alu_head),
      .o_count (w_alu_count),
      .o_full  (w_alu_full),
      .o_empty (w_alu_empty)
   );

   cdb_src_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .PTR_BIT (FIFO_PTR_BIT),
      .W       (W)
   ) u_lsb_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_flush (clear_in),
      .i_hold  (!rdy_in),
      .i_push  (w_lsb_push),
      .i_pop   (w_lsb_pop),
      .i_data  (w_lsb_in),
      .o_head  (w_lsb_head),
      .o_count (w_lsb_count),
      .o_full  (w_lsb_full),
      .o_empty (w_lsb_empty)
   );

   always_comb begin
      w_alu_cand    = !w_alu_empty || bus.alu_ready_in;
      w_lsb_cand    = !w_lsb_empty || bus.lsb_ready_in;
      w_grant_valid = w_alu_cand || w_lsb_cand;
      w_grant_src   = cdb_pick(w_alu_cand, w_lsb_cand, r_last_grant);

      if (w_grant_src == SRC_ALU) begin
         w_grant_data = w_alu_empty ? w_alu_in : w_alu_head;
      end else begin
         w_grant_data = w_lsb_empty ? w_lsb_in : w_lsb_head;
      end

      // A bypassed result goes straight to the bus and is never written into its FIFO.
      w_alu_pop  = w_grant_valid && (w_grant_src == SRC_ALU) && !w_alu_empty;
      w_lsb_pop  = w_grant_valid && (w_grant_src == SRC_LSB) && !w_lsb_empty;
      w_alu_push = bus.alu_ready_in &&
                   !(w_grant_valid && (w_grant_src == SRC_ALU) && w_alu_empty);
      w_lsb_push = bus.lsb_ready_in &&
                   !(w_grant_valid && (w_grant_src == SRC_LSB) && w_lsb_empty);
   end

   // Id and value hold across idle, clear and stall; only the valid bit drops.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_cdb_ready  <= 1'b0;
         r_cdb_rob_id <= '0;
         r_cdb_val    <= '0;
         r_last_grant <= SRC_LSB;
      end else if (clear_in) begin
         r_cdb_ready  <= 1'b0;
         r_last_grant <= SRC_LSB;
      end else if (rdy_in) begin
         if (w_grant_valid) begin
            r_cdb_ready  <= 1'b1;
            r_cdb_rob_id <= w_grant_data[W-1:32];
            r_cdb_val    <= w_grant_data[31:0];
            r_last_grant <= w_grant_src;
         end else begin
            r_cdb_ready  <= 1'b0;
         end
      end
   end

   assign bus.alu_full_out   = w_alu_full;
   assign bus.lsb_full_out   = w_lsb_full;
   assign bus.cdb_ready_out  = r_cdb_ready;
   assign bus.cdb_rob_id_out = r_cdb_rob_id;
   assign bus.cdb_val_out    = r_cdb_val;
   assign bus.dbg_alu_count  = w_alu_count;
   assign bus.dbg_lsb_count  = w_lsb_count;
   assign bus.dbg_last_grant = r_last_grant;

endmodule
